// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - microsequencer stepping a 16-bit single-operand alu through a stored opcode program

module alu (
    input  logic [2:0]  op,
    input  logic [15:0] a,
    output logic [15:0] y
);
    always_comb begin
        y = a;
        case (op)
            3'b000: y = a + 16'h0001;
            3'b001: y = a - 16'h0001;
            3'b010: y = ~a;
            3'b011: y = a & 16'h0FFF;
            3'b100: y = {a[14:0], 1'b0};
            3'b101: y = {1'b0, a[15:1]};
            3'b110: y = a | 16'h00FF;
            3'b111: y = 16'h0000;
            default: y = a;
        endcase
    end
endmodule

module alu_sequencer #(
    parameter int PROG_DEPTH = 8,
    localparam int AW = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [2:0]    prog_opcode,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic [15:0]   operand,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [15:0]   result,
    output logic          zero_flag
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(PROG_DEPTH);
    localparam logic [AW:0]   LEN_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PC_ONE  = AW'(1);

    state_t        state_q, state_d;
    logic [2:0]    mem [PROG_DEPTH];
    logic [15:0]   acc;
    logic [AW-1:0] pc;
    logic [AW:0]   len;
    logic [AW:0]   len_sat;
    logic [15:0]   alu_y;
    logic          accept;
    logic          last_step;
    logic          finish_run;
    logic          finish_empty;

    alu u_alu (
        .op (mem[pc]),
        .a  (acc),
        .y  (alu_y)
    );

    assign len_sat = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && len_sat != '0) state_d = RUN;
            RUN:  if (abort || last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == RUN);
        accept       = (state_q == IDLE) && start;
        last_step    = ({1'b0, pc} == len - LEN_ONE);
        finish_run   = busy && !abort && last_step;
        finish_empty = accept && (len_sat == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            pc        <= '0;
            len       <= '0;
            result    <= '0;
            zero_flag <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= 3'b000;
        end else begin
            done <= 1'b0;
            // program is locked while a run is in flight
            if (prog_we && !busy) mem[prog_addr] <= prog_opcode;
            if (accept) begin
                acc <= operand;
                pc  <= '0;
                len <= len_sat;
            end
            if (finish_empty) begin
                result    <= operand;
                zero_flag <= (operand == 16'h0000);
                done      <= 1'b1;
            end
            if (busy && !abort) begin
                acc <= alu_y;
                pc  <= pc + PC_ONE;
            end
            if (finish_run) begin
                result    <= alu_y;
                zero_flag <= (alu_y == 16'h0000);
                done      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with directed programs

module tb_alu_sequencer;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [2:0]    prog_opcode;
    logic [AW:0]   prog_len;
    logic          start;
    logic [15:0]   operand;
    logic          abort;
    logic          busy;
    logic          done;
    logic [15:0]   result;
    logic          zero_flag;

    int tests = 0;
    int fails = 0;
    logic [16:0] sb [$];

    alu_sequencer #(.PROG_DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_opcode (prog_opcode),
        .prog_len    (prog_len),
        .start       (start),
        .operand     (operand),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero_flag   (zero_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [2:0] op);
        prog_we = 1'b1; prog_addr = a; prog_opcode = op;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic run(input string name, input logic [AW:0] l, input logic [15:0] opnd,
                       input logic [15:0] exp_res, input int exp_busy);
        int n;
        sb.push_back({(exp_res == 16'h0000), exp_res});
        prog_len = l; operand = opnd; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        chk({name, "_busy_cycles"}, n, exp_busy);
        tick();
        chk({name, "_done_seen"}, sb.size(), 0);
    endtask

    // monitor: every done pulse must match the oldest expected completion
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected_done: got result %h, expected no done", result);
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", {16'h0, result}, {16'h0, e[15:0]});
                    chk("sb_zero", {31'h0, zero_flag}, {31'h0, e[16]});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_opcode = '0;
        prog_len = '0; start = 1'b0; operand = '0; abort = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_result", {16'h0, result}, 0);
        chk("rst_zero", {31'h0, zero_flag}, 0);

        // 1: inc, inc, shl
        wr(3'd0, 3'b000); wr(3'd1, 3'b000); wr(3'd2, 3'b100);
        run("t1", 4'd3, 16'h0005, 16'h000E, 3);

        // 2: wrap both directions
        wr(3'd0, 3'b000);
        run("t2a", 4'd1, 16'hFFFF, 16'h0000, 1);
        wr(3'd0, 3'b001);
        run("t2b", 4'd1, 16'h0000, 16'hFFFF, 1);

        // write and start in the same cycle: step 0 sees the new opcode
        prog_we = 1'b1; prog_addr = 3'd0; prog_opcode = 3'b000;
        run("same_cycle_wr", 4'd1, 16'h0007, 16'h0008, 1);
        prog_we = 1'b0;

        // 3: zero-length program
        run("t3", 4'd0, 16'h1234, 16'h1234, 0);

        // 4: full program
        wr(3'd0, 3'b010); wr(3'd1, 3'b011); wr(3'd2, 3'b100); wr(3'd3, 3'b101);
        wr(3'd4, 3'b110); wr(3'd5, 3'b001); wr(3'd6, 3'b000); wr(3'd7, 3'b101);
        run("t4", 4'd8, 16'h00F0, 16'h07FF, 8);

        // 5: abort in the third run cycle, with start/prog_we mid-run
        for (int i = 0; i < 8; i++) wr(AW'(i), 3'b001);
        prog_len = 4'd8; operand = 16'h0010; start = 1'b1;
        tick();
        prog_we = 1'b1; prog_addr = 3'd0; prog_opcode = 3'b111;
        operand = 16'h4444;
        tick();
        start = 1'b0; prog_we = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_done", {31'h0, done}, 0);
        chk("abort_result", {16'h0, result}, 32'h07FF);
        tick();
        run("t5_rerun", 4'd8, 16'h0010, 16'h0008, 8);

        // 6: reset mid-run, then saturated length
        prog_len = 4'd8; operand = 16'h0005; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", {31'h0, busy}, 0);
        chk("rst_mid_done", {31'h0, done}, 0);
        chk("rst_mid_result", {16'h0, result}, 0);
        chk("rst_mid_zero", {31'h0, zero_flag}, 0);
        run("t6_cleared", 4'd2, 16'h0001, 16'h0003, 2);
        run("t6_sat", 4'd15, 16'h0001, 16'h0009, 8);

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Microsequencer that drives the 16-bit single-operand ALU (opcodes 000 inc, 001 dec, 010 invert, 011 mask-low-12, 100 shl1, 101 shr1, 110 or-0x00FF, 111 clear) through a short stored program of opcodes.
- Loads an operand into an internal accumulator, then applies one programmed opcode per cycle, feeding each ALU result back as the next input.
- Reports the final value with a done pulse.
- Instantiates the existing combinational alu module internally; sits between the control path and the shared ALU datapath.

Parameters:
PROG_DEPTH, 8, number of opcode slots in program memory (power of two, >=2)
AW, $clog2(PROG_DEPTH), program address width (derived, not overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
prog_we  input  1  program memory write enable
prog_addr  input  AW  program write address
prog_opcode  input  3  opcode written to prog_addr
prog_len  input  AW+1  number of steps to run, sampled on accepted start
start  input  1  start request, accepted only when not busy
operand  input  16  initial accumulator value, sampled on accepted start
abort  input  1  cancel a running program
busy  output  1  high while a program is running
done  output  1  one-cycle pulse when a program completes
result  output  16  final accumulator value of last completed run
zero_flag  output  1  result == 16'h0000, registered with result

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; busy=0, done=0, result=16'h0000, zero_flag=0, acc=0, pc=0; all program slots cleared to 3'b000. Reset mid-run behaves the same; no done.
- States: IDLE, RUN. Any registered signal not listed as changing holds its value.
- Program writes:
  - prog_we=1 and busy=0: mem[prog_addr] <= prog_opcode at that edge.
  - prog_we while busy=1 is ignored. The program is locked during a run.
- IDLE, start=1:
  - acc <= operand, pc <= 0, len <= min(prog_len, PROG_DEPTH).
  - If len!=0: busy <= 1, go to RUN.
  - If len==0: next edge gives result=operand, zero_flag updated, done=1. busy stays 0 and state stays IDLE. This is a 1-cycle completion.
- RUN, each edge:
  - acc <= alu(acc, mem[pc]), pc <= pc+1.
  - On the edge applying step len-1: result <= ALU output, zero_flag <= (ALU output==0), done <= 1, busy <= 0, go to IDLE.
- Latency: start accepted at edge E; step k (0-based) is applied at edge E+1+k; done is high in the cycle after edge E+len. busy is high for exactly len cycles.
- done is a single-cycle pulse and is cleared on the next edge, unless a new completion occurs at that edge.
- Arithmetic: 16-bit, modulo 2^16. Increment of 0xFFFF gives 0x0000; decrement of 0x0000 gives 0xFFFF. No carry or flags other than zero_flag.
- start while busy=1 is ignored. No queuing.
- abort:
  - RUN, abort=1: go to IDLE, busy <= 0. No done; result and zero_flag unchanged; acc is discarded.
  - abort takes priority over a completion on the same edge.
  - In IDLE, abort is ignored; start in the same cycle is still accepted.
- start and prog_we in the same IDLE cycle: the write commits at that edge. The first RUN step reads memory after the edge, so it sees the new value.
- result and zero_flag are updated only on completion, never mid-run.

Test Plan:
1. Program [000,000,100], prog_len=3, operand=0x0005, start → busy high 3 cycles, then done pulse with result=0x000E and zero_flag=0.
2. Program [000], prog_len=1, operand=0xFFFF → result=0x0000, zero_flag=1 (wrap). Then program [001], operand=0x0000 → result=0xFFFF.
3. prog_len=0, operand=0x1234, start → done one cycle later, result=0x1234, busy never high.
4. Full program [010,011,100,101,110,001,000,101], prog_len=8, operand=0x00F0 → after 8 busy cycles, result=0x07FF. Intermediate values are 0xFF0F, 0x0F0F, 0x1E1E, 0x0F0F, 0x0FFF, 0x0FFE, 0x0FFF.
5. Program of eight 001 ops, operand=0x0010, abort in 3rd RUN cycle → busy drops next edge, no done, result keeps prior 0x07FF. start and prog_we pulsed mid-run have no effect; a rerun after abort gives 0x0008.
6. Assert rst mid-run → all outputs 0 next cycle, program reads back as 000 (len=2, operand=0x0001 → result=0x0003). prog_len=15 saturates to 8 steps.
